// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with one-entry skid buffer and redirect discard
module if_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  // Redirect target parked while the old request drains in DISCARD;
  // pc keeps the old address so imem_addr stays stable until ready.
  logic [31:0] target, target_nxt;
  logic [31:0] skid_instr, skid_instr_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
  logic [31:0] instr_nxt, pc_out_nxt;
  logic        valid_nxt, req_nxt;
  logic        accept;

  assign imem_addr = pc;
  // imem_ready is meaningless unless a request is actually outstanding.
  assign accept    = imem_req & imem_ready;

  // Next-state and next-output decode; redirect takes priority over stall.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    target_nxt     = target;
    skid_instr_nxt = skid_instr;
    skid_pc_nxt    = skid_pc;
    instr_nxt      = instr_out;
    pc_out_nxt     = pc_out;
    valid_nxt      = valid_out;
    req_nxt        = imem_req;

    if (redirect) begin
      valid_nxt      = 1'b0;
      skid_instr_nxt = 32'd0;
      skid_pc_nxt    = 32'd0;
      req_nxt        = 1'b1;
      case (state)
        DISCARD: begin
          if (imem_ready) begin
            pc_nxt    = redirect_pc;
            state_nxt = FETCH;
          end else begin
            target_nxt = redirect_pc;
          end
        end
        FETCH: begin
          if (imem_req && !imem_ready) begin
            target_nxt = redirect_pc;
            state_nxt  = DISCARD;
          end else begin
            pc_nxt    = redirect_pc;
            state_nxt = FETCH;
          end
        end
        default: begin
          pc_nxt    = redirect_pc;
          state_nxt = FETCH;
        end
      endcase
    end else begin
      case (state)
        FETCH: begin
          req_nxt = 1'b1;
          if (accept && !stall) begin
            instr_nxt  = imem_rdata;
            pc_out_nxt = pc;
            valid_nxt  = 1'b1;
            pc_nxt     = pc + 32'd1;
          end else if (accept && stall) begin
            skid_instr_nxt = imem_rdata;
            skid_pc_nxt    = pc;
            pc_nxt         = pc + 32'd1;
            req_nxt        = 1'b0;
            state_nxt      = HOLD;
          end else if (!stall) begin
            valid_nxt = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_nxt  = skid_instr;
            pc_out_nxt = skid_pc;
            valid_nxt  = 1'b1;
            req_nxt    = 1'b1;
            state_nxt  = FETCH;
          end
        end
        DISCARD: begin
          if (imem_ready) begin
            pc_nxt    = target;
            state_nxt = FETCH;
          end
        end
        default: begin
          state_nxt = FETCH;
        end
      endcase
    end
  end

  // State, PC, skid buffer and IF/ID registers; reset abandons any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= 32'd0;
      target     <= 32'd0;
      skid_instr <= 32'd0;
      skid_pc    <= 32'd0;
      instr_out  <= 32'd0;
      pc_out     <= 32'd0;
      valid_out  <= 1'b0;
      imem_req   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      target     <= target_nxt;
      skid_instr <= skid_instr_nxt;
      skid_pc    <= skid_pc_nxt;
      instr_out  <= instr_nxt;
      pc_out     <= pc_out_nxt;
      valid_out  <= valid_nxt;
      imem_req   <= req_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized and directed checks of if_fetch against a queue-based model
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect, imem_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, valid_out;
  logic [31:0] imem_addr, instr_out, pc_out;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  bit mem_mode = 1'b0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  // Model: the address being requested, whether a request is out,
  // the IF/ID contents, captured-but-undelivered instructions, and
  // an optional "drop the next return, then go to target" obligation.
  logic [31:0] m_addr, m_instr, m_pcout, m_target;
  logic        m_req, m_valid, m_drop;
  entry_t      m_skid[$];

  if_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_out(instr_out),
    .pc_out(pc_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem_mode) return 32'h1000_0000 + a;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = 0; m_instr = 0; m_pcout = 0; m_target = 0;
    m_req = 0; m_valid = 0; m_drop = 0;
    m_skid.delete();
  endtask

  task automatic model_step(input bit s, input bit r, input logic [31:0] rp, input bit rdy);
    logic [31:0] d;
    entry_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    d = mem_word(m_addr);
    if (r) begin
      m_skid.delete();
      m_valid = 0;
      if (m_drop) begin
        if (rdy) begin m_addr = rp; m_drop = 0; end
        else m_target = rp;
      end else if (m_req && !rdy) begin
        m_drop = 1; m_target = rp;
      end else begin
        m_addr = rp;
      end
      m_req = 1;
    end else if (m_drop) begin
      if (rdy) begin m_addr = m_target; m_drop = 0; end
    end else if (m_skid.size() != 0) begin
      if (!s) begin
        e = m_skid.pop_front();
        m_instr = e.instr; m_pcout = e.pc; m_valid = 1; m_req = 1;
      end
    end else begin
      if (m_req && rdy && !s) begin
        m_instr = d; m_pcout = m_addr; m_valid = 1; m_addr = m_addr + 1;
      end else if (m_req && rdy && s) begin
        e.instr = d; e.pc = m_addr;
        m_skid.push_back(e);
        m_addr = m_addr + 1;
      end else if (!s) begin
        m_valid = 0;
      end
      m_req = (m_skid.size() == 0);
    end
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req", {31'd0, imem_req}, {31'd0, m_req});
      check("imem_addr", imem_addr, m_addr);
      check("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
      check("pc_out", pc_out, m_pcout);
      check("instr_out", instr_out, m_instr);
    end
  end

  // Drive one cycle of inputs shortly after a falling edge, advance model, wait a cycle.
  task automatic step(input bit s, input bit r, input logic [31:0] rp, input bit rdy);
    stall = s; redirect = r; redirect_pc = rp; imem_ready = rdy;
    imem_rdata = rdy ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    model_step(s, r, rp, rdy);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  logic [31:0] held_addr;

  initial begin
    rst_n = 1'b0; stall = 0; redirect = 0; redirect_pc = 0; imem_ready = 1; imem_rdata = 0;
    model_reset();
    @(negedge clk); #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_instr", instr_out, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    chk_en = 1'b1;
    rst_n = 1'b1;

    // Streaming with memory always ready.
    step(0, 0, 0, 1);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'd0);
    step(0, 0, 0, 1);
    check("first_valid", {31'd0, valid_out}, 32'd1);
    check("first_pc", pc_out, 32'd0);
    check("first_instr", instr_out, 32'h1000_0000);
    step(0, 0, 0, 1);
    check("second_pc", pc_out, 32'd1);
    check("second_instr", instr_out, 32'h1000_0001);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // Stall three cycles with memory ready: one capture, then request drops.
    step(1, 0, 0, 1);
    check("stall_req_drop", {31'd0, imem_req}, 32'd0);
    check("stall_pc_frozen", pc_out, 32'd5);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    check("unstall_pc", pc_out, 32'd6);
    step(0, 0, 0, 1);
    check("unstall_next_pc", pc_out, 32'd7);

    // Redirect while memory not ready: old address held, its data dropped.
    held_addr = imem_addr;
    step(0, 1, 32'h40, 0);
    check("disc_addr_held", imem_addr, held_addr);
    check("disc_valid", {31'd0, valid_out}, 32'd0);
    step(0, 0, 0, 0);
    check("disc_addr_held2", imem_addr, held_addr);
    step(0, 0, 0, 1);
    check("disc_new_addr", imem_addr, 32'h40);
    check("disc_valid2", {31'd0, valid_out}, 32'd0);
    step(0, 0, 0, 1);
    check("disc_first_pc", pc_out, 32'h40);

    // Redirect plus stall with a full skid buffer.
    step(1, 0, 0, 1);
    step(1, 1, 32'h80, 0);
    step(0, 0, 0, 1);
    check("skid_redir_pc", pc_out, 32'h80);
    check("skid_redir_valid", {31'd0, valid_out}, 32'd1);

    // PC wrap.
    step(0, 1, 32'hFFFF_FFFF, 1);
    step(0, 0, 0, 1);
    check("wrap_addr", imem_addr, 32'd0);
    check("wrap_pc", pc_out, 32'hFFFF_FFFF);

    // Reset asserted mid-cycle during DISCARD.
    step(0, 1, 32'h200, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_disc_req", {31'd0, imem_req}, 32'd0);
    check("rst_disc_addr", imem_addr, 32'd0);
    check("rst_disc_valid", {31'd0, valid_out}, 32'd0);
    step(0, 0, 0, 1);
    rst_n = 1'b1;
    step(0, 0, 0, 1);
    check("restart_addr", imem_addr, 32'd0);
    step(0, 0, 0, 1);
    check("restart_pc", pc_out, 32'd0);

    // Randomized traffic.
    mem_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit s, r, rdy;
      logic [31:0] rp;
      s   = ($urandom % 4) == 0;
      r   = ($urandom % 12) == 0;
      rdy = ($urandom % 3) != 0;
      rp  = (($urandom % 8) == 0) ? (32'hFFFF_FFFE + ($urandom % 2)) : $urandom;
      if (($urandom % 300) == 0) begin
        rst_n = 1'b0;
        model_reset();
        step(s, r, rp, rdy);
        rst_n = 1'b1;
      end else begin
        step(s, r, rp, rdy);
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
